// File: rtl/atm_account_responder.sv
// Account-side responder: one request at a time, PIN check with lockout,
// balance arithmetic with insufficient-funds / overflow detection.
module atm_account_responder #(
   parameter int               BAL_W        = 32,
   parameter logic [BAL_W-1:0] INIT_BALANCE = 32'h000F4240,
   parameter logic [3:0]       PIN_VALUE    = 4'b1010,
   parameter int               MAX_TRIES    = 3,
   parameter int               LATENCY      = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [3:0]       req_pin,
   input  logic [BAL_W-1:0] req_amount,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [2:0]       rsp_status,
   output logic [BAL_W-1:0] rsp_balance,
   output logic             session_open,
   output logic             locked
);

   // state | meaning
   // IDLE  | ready for a request
   // EXEC  | request captured, latency countdown running
   // RESP  | response held until consumer takes it
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

   localparam int CNT_W  = $clog2(LATENCY + 1);
   localparam int FAIL_W = $clog2(MAX_TRIES + 1);

   localparam logic [2:0] OP_VERIFY = 3'd0, OP_BALANCE = 3'd1, OP_WITHDRAW = 3'd2,
                          OP_DEPOSIT = 3'd3, OP_CLOSE = 3'd4;
   localparam logic [2:0] S_OK = 3'd0, S_BAD_PIN = 3'd1, S_LOCKED = 3'd2, S_NO_SESSION = 3'd3,
                          S_INSUFFICIENT = 3'd4, S_OVERFLOW = 3'd5, S_BAD_OP = 3'd6;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [3:0]         pin_q, pin_d;
   logic [BAL_W-1:0]   amount_q, amount_d;
   logic [BAL_W-1:0]   balance_q, balance_d;
   logic [2:0]         status_q, status_d;
   logic               session_q, session_d;
   logic [FAIL_W-1:0]  fail_q, fail_d;
   logic               locked_q, locked_d;

   logic [2:0]         res_status;
   logic [BAL_W-1:0]   res_balance;
   logic               res_session;
   logic [FAIL_W-1:0]  res_fail;
   logic               res_locked;
   logic [FAIL_W-1:0]  fail_inc;
   logic [BAL_W:0]     dep_sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         pin_q     <= '0;
         amount_q  <= '0;
         balance_q <= INIT_BALANCE;
         status_q  <= S_OK;
         session_q <= 1'b0;
         fail_q    <= '0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         pin_q     <= pin_d;
         amount_q  <= amount_d;
         balance_q <= balance_d;
         status_q  <= status_d;
         session_q <= session_d;
         fail_q    <= fail_d;
         locked_q  <= locked_d;
      end
   end

   // Result of the captured request against the current account record
   always_comb begin
      res_status  = S_OK;
      res_balance = balance_q;
      res_session = session_q;
      res_fail    = fail_q;
      res_locked  = locked_q;
      fail_inc    = fail_q + 1'b1;
      dep_sum     = {1'b0, balance_q} + {1'b0, amount_q};
      if (locked_q) begin
         res_status  = S_LOCKED;
         res_session = 1'b0;
      end else begin
         case (op_q)
            OP_VERIFY: begin
               if (pin_q == PIN_VALUE) begin
                  res_session = 1'b1;
                  res_fail    = '0;
               end else begin
                  res_status  = S_BAD_PIN;
                  res_session = 1'b0;
                  res_fail    = fail_inc;
                  if (int'(fail_inc) >= MAX_TRIES) res_locked = 1'b1;
               end
            end
            OP_CLOSE: res_session = 1'b0;
            OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT: begin
               if (!session_q) begin
                  res_status = S_NO_SESSION;
               end else if (op_q == OP_WITHDRAW) begin
                  if (amount_q > balance_q) res_status  = S_INSUFFICIENT;
                  else                      res_balance = balance_q - amount_q;
               end else if (op_q == OP_DEPOSIT) begin
                  if (dep_sum[BAL_W]) res_status  = S_OVERFLOW;
                  else                res_balance = dep_sum[BAL_W-1:0];
               end
            end
            default: res_status = S_BAD_OP;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      pin_d     = pin_q;
      amount_d  = amount_q;
      balance_d = balance_q;
      status_d  = status_q;
      session_d = session_q;
      fail_d    = fail_q;
      locked_d  = locked_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d     = req_op;
               pin_d    = req_pin;
               amount_d = req_amount;
               cnt_d    = CNT_W'(LATENCY - 1);
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               status_d  = res_status;
               balance_d = res_balance;
               session_d = res_session;
               fail_d    = res_fail;
               locked_d  = res_locked;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = (state_q == ST_IDLE);
      rsp_valid    = (state_q == ST_RESP);
      rsp_status   = status_q;
      rsp_balance  = balance_q;
      session_open = session_q;
      locked       = locked_q;
   end

endmodule

// File: tb/tb_atm_account_responder.sv
// Directed bench for atm_account_responder: driver queues expected responses,
// an independent monitor checks each response on its handshake.
module tb_atm_account_responder;
   localparam int          LAT  = 2;
   localparam logic [31:0] INIT = 32'h000F4240;
   localparam logic [3:0]  GOOD = 4'b1010;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [3:0]  req_pin = 4'd0;
   logic [31:0] req_amount = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [2:0]  rsp_status;
   logic [31:0] rsp_balance;
   logic        session_open;
   logic        locked;

   always #5 clk = ~clk;

   atm_account_responder #(
      .BAL_W(32), .INIT_BALANCE(INIT), .PIN_VALUE(GOOD), .MAX_TRIES(3), .LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_pin(req_pin), .req_amount(req_amount),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
      .rsp_balance(rsp_balance), .session_open(session_open), .locked(locked)
   );

   typedef struct {
      logic [2:0]  st;
      logic [31:0] bal;
      logic        sess;
      logic        lock;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("rsp_status", {29'd0, rsp_status}, {29'd0, mon_e.st});
            chk("rsp_balance", rsp_balance, mon_e.bal);
            chk("session_open", {31'd0, session_open}, {31'd0, mon_e.sess});
            chk("locked", {31'd0, locked}, {31'd0, mon_e.lock});
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [3:0] pin, input logic [31:0] amt,
                       input logic [2:0] st, input logic [31:0] bal, input logic sess,
                       input logic lock, input int hold = 0);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_pin = pin; req_amount = amt;
      q.push_back('{st, bal, sess, lock});
      @(posedge clk); #1;
      // scramble inputs after accept: the captured values must be used
      req_valid = 1'b0; req_op = 3'b111; req_pin = ~pin; req_amount = 32'hFFFFFFFF;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("latency", n, LAT);
      if (hold > 0) begin
         rsp_ready = 1'b0;
         req_valid = 1'b1; req_op = 3'd3; req_amount = 32'd5;
         repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_status", {29'd0, rsp_status}, {29'd0, st});
            chk("hold_balance", rsp_balance, bal);
         end
         @(posedge clk); #1;
         req_valid = 1'b0; rsp_ready = 1'b1;
      end
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("complete", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_status", {29'd0, rsp_status}, 32'd0);
      chk("rst_balance", rsp_balance, INIT);
      chk("rst_session", {31'd0, session_open}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      // session, balance, withdrawals
      send(3'd0, GOOD, 32'd0, 3'd0, INIT, 1'b1, 1'b0);
      send(3'd1, 4'd0, 32'd0, 3'd0, INIT, 1'b1, 1'b0);
      send(3'd2, 4'd0, 32'd1000, 3'd0, 32'd999000, 1'b1, 1'b0);
      send(3'd2, 4'd0, 32'd1000000, 3'd4, 32'd999000, 1'b1, 1'b0);
      send(3'd2, 4'd0, 32'd0, 3'd0, 32'd999000, 1'b1, 1'b0);
      send(3'd2, 4'd0, 32'd999000, 3'd0, 32'd0, 1'b1, 1'b0);
      // deposit overflow boundary
      send(3'd3, 4'd0, 32'hFFFFFFF0, 3'd0, 32'hFFFFFFF0, 1'b1, 1'b0);
      send(3'd3, 4'd0, 32'h10, 3'd5, 32'hFFFFFFF0, 1'b1, 1'b0);
      send(3'd3, 4'd0, 32'hF, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0);

      // lockout
      do_reset();
      send(3'd1, 4'd0, 32'd0, 3'd3, INIT, 1'b0, 1'b0);
      send(3'd0, 4'd0, 32'd0, 3'd1, INIT, 1'b0, 1'b0);
      send(3'd0, 4'd0, 32'd0, 3'd1, INIT, 1'b0, 1'b0);
      send(3'd0, 4'd0, 32'd0, 3'd1, INIT, 1'b0, 1'b1);
      send(3'd0, GOOD, 32'd0, 3'd2, INIT, 1'b0, 1'b1);
      send(3'd7, 4'd0, 32'd0, 3'd2, INIT, 1'b0, 1'b1);
      send(3'd4, 4'd0, 32'd0, 3'd2, INIT, 1'b0, 1'b1);

      // good PIN clears the fail count
      do_reset();
      send(3'd0, 4'd1, 32'd0, 3'd1, INIT, 1'b0, 1'b0);
      send(3'd0, GOOD, 32'd0, 3'd0, INIT, 1'b1, 1'b0);
      send(3'd0, 4'd2, 32'd0, 3'd1, INIT, 1'b0, 1'b0);
      send(3'd0, 4'd3, 32'd0, 3'd1, INIT, 1'b0, 1'b0);
      send(3'd0, GOOD, 32'd0, 3'd0, INIT, 1'b1, 1'b0);
      send(3'd4, 4'd0, 32'd0, 3'd0, INIT, 1'b0, 1'b0);
      send(3'd5, 4'd0, 32'd0, 3'd6, INIT, 1'b0, 1'b0);

      // back-pressure: response frozen, new request ignored
      send(3'd1, 4'd0, 32'd0, 3'd3, INIT, 1'b0, 1'b0, 5);
      repeat (3) begin
         @(negedge clk);
         chk("ignored_req", {31'd0, rsp_valid}, 32'd0);
      end

      // reset while executing drops the transaction
      send(3'd0, GOOD, 32'd0, 3'd0, INIT, 1'b1, 1'b0);
      send(3'd2, 4'd0, 32'd1000, 3'd0, 32'd999000, 1'b1, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd2; req_amount = 32'd500;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("exec_busy", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("drop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("drop_req_ready", {31'd0, req_ready}, 32'd1);
      chk("drop_balance", rsp_balance, INIT);
      chk("drop_session", {31'd0, session_open}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      send(3'd0, GOOD, 32'd0, 3'd0, INIT, 1'b1, 1'b0);
      send(3'd1, 4'd0, 32'd0, 3'd0, INIT, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/atm_account_responder.md
# atm_account_responder

Account-side responder for the ATM controller's transaction requests. It accepts one request at a time over a valid/ready channel (PIN verify, balance query, withdraw, deposit, close session), checks the PIN with a lockout counter, and applies balance arithmetic with insufficient-funds and overflow checks. It returns a status code and the resulting balance over a second valid/ready channel. It sits between the ATM front-end FSM and the (single) account record it owns.

## Interface
- BAL_W, 32, balance/amount width in bits
- INIT_BALANCE, 32'h000F4240, balance loaded at reset
- PIN_VALUE, 4'b1010, correct PIN
- MAX_TRIES, 3, consecutive bad PINs that cause lockout (≥1)
- LATENCY, 2, edges from request accept to response valid (≥1)

- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_op  in  3  000 VERIFY, 001 BALANCE, 010 WITHDRAW, 011 DEPOSIT, 100 CLOSE, others illegal
- req_pin  in  4  PIN, used by VERIFY only
- req_amount  in  BAL_W  unsigned amount, used by WITHDRAW/DEPOSIT only
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 NO_SESSION, 4 INSUFFICIENT, 5 OVERFLOW, 6 BAD_OP
- rsp_balance  out  BAL_W  balance after the request (unchanged value on any error)
- session_open  out  1  PIN verified, session active
- locked  out  1  lockout active

## Operation
- States: IDLE (req_ready=1), EXEC (busy, latency countdown), RESP (rsp_valid=1). req_ready is 0 in EXEC and RESP.
- Accept: req_valid & req_ready at an edge; req_op/req_pin/req_amount captured on that edge; later input changes ignored.
- Evaluation order: locked → LOCKED; illegal op → BAD_OP; VERIFY; CLOSE; other ops without session → NO_SESSION.
- VERIFY: pin match → OK, session_open=1, fail count=0. Mismatch → BAD_PIN, fail count+1, session_open=0; count reaching MAX_TRIES → locked=1, status still BAD_PIN for that request.
- CLOSE: always OK (if not locked), session_open=0, fail count unchanged.
- BALANCE: OK, balance unchanged.
- WITHDRAW: amount > balance → INSUFFICIENT; else balance −= amount, OK. Amount 0 → OK, no change. Amount == balance → OK, balance 0.
- DEPOSIT: balance+amount computed at BAL_W+1 bits; carry set → OVERFLOW, no change; else OK.
- Balance, session, fail count and locked commit on the edge that raises rsp_valid; rsp_balance shows post-commit balance.
- locked persists until reset; lockout also forces session_open=0.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=INIT_BALANCE, session_open=0, locked=0, balance=INIT_BALANCE, fail count=0, state IDLE.
- Accept at edge T → EXEC; rsp_valid rises at edge T+LATENCY; rsp_status/rsp_balance stable while rsp_valid=1.
- Response completes at the first edge with rsp_valid & rsp_ready; rsp_valid falls and req_ready rises on that same edge (state IDLE). Earliest next accept is the following edge: throughput one request per LATENCY+2 cycles with rsp_ready held high.
- rsp_ready high before rsp_valid has no effect; rsp_ready low holds RESP indefinitely with outputs frozen.
- Reset asserted in EXEC or RESP: transaction dropped, no commit, all outputs to reset values immediately.

## Test plan
- Reset, VERIFY pin 4'b1010, then BALANCE → both OK, rsp_balance=32'h000F4240, session_open=1; rsp_valid rises exactly 2 edges after accept.
- Session open, WITHDRAW 1000 → OK, balance 999000; WITHDRAW 1000000 → INSUFFICIENT, balance 999000; WITHDRAW 999000 → OK, balance 0.
- Session open with balance 32'hFFFFFFF0, DEPOSIT 32'h10 → OVERFLOW, balance unchanged; DEPOSIT 32'hF → OK, balance 32'hFFFFFFFF.
- After reset, BALANCE → NO_SESSION; VERIFY 4'b0000 three times → BAD_PIN ×3, locked=1 after the third; VERIFY 4'b1010 → LOCKED; opcode 3'b111 → LOCKED.
- VERIFY bad, VERIFY good, VERIFY bad, VERIFY bad → no lockout (count reset by good PIN); CLOSE → OK, session_open=0; op 3'b101 while unlocked → BAD_OP.
- Hold rsp_ready=0 for 5 cycles in RESP → outputs frozen, req_ready=0, new req_valid ignored; assert reset during EXEC of WITHDRAW 500 → balance remains INIT_BALANCE, rsp_valid=0.
